lmem_stream_reader: RTL and testbench

//  Read-side streaming engine for a TyTra LMEM instance. On a start pulse it walks
//  LEN consecutive addresses from BASE through the LMEM read port (registered q, 1-cycle latency).
//  It emits the words as a valid/ready stream into the datapath. The counterpart of the

---
 rtl/lmem_stream_reader_pkg.sv | 17 +
 rtl/lmem_rd_fifo.sv | 58 +++++
 rtl/lmem_stream_reader.sv | 130 +++++++++++++
 tb/tb_lmem_stream_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmem_stream_reader_pkg.sv
// Shared types for the LMEM stream reader: FSM state encoding and FIFO sizing helper.
// States keep the 2-bit IDLE/ISSUE/DRAIN/DONE encoding used by the other LMEM wrappers.
package lmem_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lmem_rd_fifo.sv
// Output skid FIFO for LMEM reads: registered storage, show-ahead head, 1-cycle push-to-head latency.
// Pop is ignored when empty; push is refused when full unless a pop frees the slot in the same cycle.
module lmem_rd_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [DATA_WIDTH-1:0]         i_din,
  output logic [DATA_WIDTH-1:0]         o_dout,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lmem_stream_reader.sv
// Streams LEN words from LMEM[BASE..] to a valid/ready port; first word 3 cycles after start, then 1/cycle.
// Backpressure: reads are issued only while FIFO occupancy plus in-flight reads leaves room, so nothing drops.
module lmem_stream_reader
  import lmem_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_q,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int PW = CW + 1;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH:0]   r_words_left;
  logic                  r_issue_vld;
  logic                  r_tag;

  logic [CW-1:0]         w_count;
  logic                  w_empty;
  logic                  w_pop;
  logic [PW-1:0]         w_pending;
  logic                  w_gate;
  logic [DATA_WIDTH-1:0] w_dout;

  // In-flight reads: one on the address bus (r_issue_vld), one on mem_q (r_tag).
  assign w_pending = PW'(w_count) + PW'(r_issue_vld) + PW'(r_tag);
  assign w_gate    = (w_pending < PW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && i_out_ready;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mem_addr  = r_mem_addr;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_dout;

  lmem_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_tag),
    .i_pop   (w_pop),
    .i_din   (i_mem_q),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_addr   <= '0;
      r_remaining  <= '0;
      r_words_left <= '0;
      r_issue_vld  <= 1'b0;
      r_tag        <= 1'b0;
    end else begin
      r_tag  <= r_issue_vld;
      r_done <= 1'b0;
      if (w_pop && (r_words_left != '0)) begin
        r_words_left <= r_words_left - 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_issue_vld <= 1'b0;
          if (i_start) begin
            if (i_length == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              // The accepting edge also issues the first read.
              r_mem_addr   <= i_base_addr;
              r_issue_vld  <= 1'b1;
              r_remaining  <= i_length - 1'b1;
              r_words_left <= i_length;
              r_busy       <= 1'b1;
              r_state      <= (i_length == (ADDR_WIDTH+1)'(1)) ? ST_DRAIN : ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_gate) begin
            r_mem_addr  <= r_mem_addr + 1'b1;
            r_issue_vld <= 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == (ADDR_WIDTH+1)'(1)) begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_issue_vld <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_issue_vld <= 1'b0;
          if (w_pop && (r_words_left == (ADDR_WIDTH+1)'(1))) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_issue_vld <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmem_stream_reader.sv
// Bench for lmem_stream_reader: 1-cycle RAM preloaded with i+100, scoreboard of expected stream words.
module tb_lmem_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  mem_addr;
  logic [17:0] mem_q;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [17:0] mem [256];
  logic [17:0] sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 18'(i + 100);
  end

  always @(posedge clk) mem_q <= mem[mem_addr];

  lmem_stream_reader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_length    (length),
    .o_busy      (busy),
    .o_done      (done),
    .o_mem_addr  (mem_addr),
    .i_mem_q     (mem_q),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int base, input int len);
    start     = 1'b1;
    base_addr = 8'(base);
    length    = 9'(len);
    for (int i = 0; i < len; i++) sb.push_back(18'(((base + i) % 256) + 100));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: busy/done/valid got %b want 000", {busy, done, out_valid});
    end
    n_cmp++;
    if (out_data !== 18'd0 || mem_addr !== 8'd0) begin
      n_err++; $display("FAIL reset_data: data %0d addr %0d want 0 0", out_data, mem_addr);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_idle: busy/done/valid got %b want 000", {busy, done, out_valid});
    end
  endtask

  task automatic test_basic();
    logic [17:0] exp;
    next_cycle();
    out_ready = 1'b1;
    kick(5, 4);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_cmp++;
        if (mem_addr !== 8'd5) begin n_err++; $display("FAIL basic_addr: got %0d want 5", mem_addr); end
      end
      n_cmp++;
      if (done !== (cyc == 7)) begin n_err++; $display("FAIL basic_done c%0d: got %b want %b", cyc, done, cyc == 7); end
      n_cmp++;
      if (busy !== (cyc >= 1 && cyc <= 6)) begin n_err++; $display("FAIL basic_busy c%0d: got %b", cyc, busy); end
      n_cmp++;
      if (out_valid !== (cyc >= 3 && cyc <= 6)) begin
        n_err++; $display("FAIL basic_valid c%0d: got %b want %b", cyc, out_valid, cyc >= 3 && cyc <= 6);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL basic_extra: got %0d want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin n_err++; $display("FAIL basic_data: got %0d want %0d", out_data, exp); end
        end
      end
      next_cycle();
      start = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL basic_left: %0d words missing want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_zero_len();
    next_cycle();
    kick(0, 0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== (cyc == 1)) begin n_err++; $display("FAIL zero_done c%0d: got %b want %b", cyc, done, cyc == 1); end
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL zero_busy_valid c%0d: got %b%b want 00", cyc, busy, out_valid);
      end
      next_cycle();
      start = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [17:0] exp;
    logic [7:0]  exp_addr;
    next_cycle();
    out_ready = 1'b1;
    kick(254, 4);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 4) begin
        exp_addr = 8'(254 + cyc - 1);
        n_cmp++;
        if (mem_addr !== exp_addr) begin n_err++; $display("FAIL wrap_addr c%0d: got %0d want %0d", cyc, mem_addr, exp_addr); end
      end
      n_cmp++;
      if (done !== (cyc == 7)) begin n_err++; $display("FAIL wrap_done c%0d: got %b want %b", cyc, done, cyc == 7); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL wrap_extra: got %0d want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin n_err++; $display("FAIL wrap_data: got %0d want %0d", out_data, exp); end
        end
      end
      next_cycle();
      start = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL wrap_left: %0d words missing want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp;
    logic [17:0] prev_data = '0;
    logic        prev_stall = 1'b0;
    bit          seen_done = 1'b0;
    next_cycle();
    out_ready = ($urandom_range(0, 9) < 3);
    kick(0, 16);
    for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_err++; $display("FAIL bp_stable c%0d: valid %b data %0d want 1 %0d", cyc, out_valid, out_data, prev_data);
        end
      end
      n_cmp++;
      if (dut.u_fifo.o_count > 4) begin n_err++; $display("FAIL bp_count c%0d: got %0d want <=4", cyc, dut.u_fifo.o_count); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL bp_extra: got %0d want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin n_err++; $display("FAIL bp_data: got %0d want %0d", out_data, exp); end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) seen_done = 1'b1;
      next_cycle();
      start     = 1'b0;
      out_ready = ($urandom_range(0, 9) < 3);
    end
    out_ready = 1'b1;
    n_cmp++;
    if (!seen_done) begin n_err++; $display("FAIL bp_timeout: done got 0 want 1"); end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL bp_left: %0d words missing want 0", sb.size()); sb.delete(); end
    repeat (2) next_cycle();
  endtask

  task automatic test_restart_ignored();
    logic [17:0] exp;
    next_cycle();
    out_ready = 1'b1;
    kick(10, 6);
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== (cyc == 9)) begin n_err++; $display("FAIL restart_done c%0d: got %b want %b", cyc, done, cyc == 9); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL restart_extra: got %0d want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin n_err++; $display("FAIL restart_data: got %0d want %0d", out_data, exp); end
        end
      end
      next_cycle();
      start = (cyc == 2);
      if (cyc == 2) begin
        base_addr = 8'd50;
        length    = 9'd3;
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL restart_left: %0d words missing want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    int          got = 0;
    int          cyc = 0;
    next_cycle();
    out_ready = 1'b1;
    kick(0, 10);
    while (got < 3 && cyc < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        exp = sb.pop_front();
        if (out_data !== exp) begin n_err++; $display("FAIL rstmid_data: got %0d want %0d", out_data, exp); end
        got++;
      end
      next_cycle();
      start = 1'b0;
      cyc++;
    end
    n_cmp++;
    if (got != 3) begin n_err++; $display("FAIL rstmid_timeout: got %0d words want 3", got); end
    rst       = 1'b1;
    out_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, done} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_flush: busy/valid/done got %b want 000", {busy, out_valid, done});
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_quiet: done/valid got %b%b want 00", done, out_valid);
      end
    end
    next_cycle();
    out_ready = 1'b1;
    kick(0, 2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== (c == 5)) begin n_err++; $display("FAIL rstmid_done c%0d: got %b want %b", c, done, c == 5); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rstmid_extra: got %0d want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin n_err++; $display("FAIL rstmid_new: got %0d want %0d", out_data, exp); end
        end
      end
      next_cycle();
      start = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL rstmid_left: %0d words missing want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
